// File: rtl/trap_pkg.sv
// Shared constants for the E-stage trap controller: trap-CSR addresses,
// cause codes, SYSTEM funct12 encodings and the redirect FSM states.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [7:0] CAUSE_ILLEGAL  = 8'd2;
    localparam logic [7:0] CAUSE_EBREAK   = 8'd3;
    localparam logic [7:0] CAUSE_ECALL    = 8'd11;
    localparam logic [7:0] CAUSE_IRQ_BASE = 8'd16;

    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
    localparam logic [11:0] F12_URET   = 12'h002;
    localparam logic [11:0] F12_SRET   = 12'h102;
    localparam logic [11:0] F12_MRET   = 12'h302;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    // Every xRET flavour is executed as mret; there is only machine mode.
    function automatic logic is_xret(input logic [11:0] f12);
        return (f12 == F12_URET) || (f12 == F12_SRET) || (f12 == F12_MRET);
    endfunction

endpackage

// File: rtl/trap_unit_if.sv
// E-stage / fetch / CSR-unit bundle seen by the trap controller.
// master = pipeline side driving the instruction and CSR access, slave = trap_unit.
interface trap_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    logic               validE;
    logic               privilegedInstrE;
    logic               illegalInstrE;
    logic [XLEN-1:0]    immExtE;
    logic [XLEN-1:0]    pcE;
    logic [NUM_IRQ-1:0] irq;
    logic               csrWe;
    logic [11:0]        csrAddr;
    logic [XLEN-1:0]    csrWdata;
    logic [XLEN-1:0]    csrRdata;
    logic               redirect;
    logic [XLEN-1:0]    redirectPc;
    logic               redirectAck;
    logic               flush;
    logic               iret;
    logic               exception;
    logic [7:0]         exceptionCode;

    modport master (
        output validE, privilegedInstrE, illegalInstrE, immExtE, pcE, irq,
               csrWe, csrAddr, csrWdata, redirectAck,
        input  csrRdata, redirect, redirectPc, flush, iret, exception, exceptionCode
    );

    modport slave (
        input  validE, privilegedInstrE, illegalInstrE, immExtE, pcE, irq,
               csrWe, csrAddr, csrWdata, redirectAck,
        output csrRdata, redirect, redirectPc, flush, iret, exception, exceptionCode
    );
endinterface

// File: rtl/trap_unit_irq_prio_enc.sv
// Fixed-priority encoder over pending interrupt lines: lowest index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_any,
    output logic [3:0]         o_idx
);
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 4'(i);
        end
    end
endmodule

// File: rtl/trap_unit.sv
// Execute-stage trap controller: decides trap/xRET in E, owns the machine
// trap CSRs and holds a redirect/flush request toward fetch until acknowledged.
module trap_unit
    import trap_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_IRQ   = 4,
    parameter int              VECTORED  = 1,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic       clk,
    input  logic       reset,
    trap_unit_if.slave bus
);
    localparam logic [0:0] S_RUN      = RUN;
    localparam logic [0:0] S_REDIRECT = REDIRECT;
    localparam logic [XLEN-1:0] MTVEC_RST =
        (VECTORED != 0) ? RESET_VEC : (RESET_VEC & ~XLEN'(1));

    logic [0:0]         r_state;
    logic               r_mstatus_mie;
    logic               r_mstatus_mpie;
    logic [NUM_IRQ-1:0] r_mie;
    logic [XLEN-1:0]    r_mtvec;
    logic [XLEN-1:0]    r_mepc;
    logic [XLEN-1:0]    r_mcause;
    logic [XLEN-1:0]    r_redirect_pc;
    logic               r_iret;
    logic               r_exception;
    logic [7:0]         r_exc_code;

    logic [11:0]     w_funct12;
    logic            w_sample;
    logic            w_irq_any;
    logic [3:0]      w_irq_idx;
    logic            w_take_irq;
    logic            w_ebreak;
    logic            w_ecall;
    logic            w_trap;
    logic            w_xret;
    logic            w_commit;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_mtvec_wr;
    logic            w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.immExtE[19:0], bus.pcE[1:0]};

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .i_req (bus.irq & r_mie),
        .o_any (w_irq_any),
        .o_idx (w_irq_idx)
    );

    assign w_funct12  = bus.immExtE[31:20];
    assign w_sample   = (r_state == S_RUN) && bus.validE;
    assign w_take_irq = w_sample && r_mstatus_mie && w_irq_any;
    assign w_ebreak   = bus.privilegedInstrE && (w_funct12 == F12_EBREAK);
    assign w_ecall    = bus.privilegedInstrE && (w_funct12 == F12_ECALL);
    assign w_trap     = w_take_irq || (w_sample && (bus.illegalInstrE || w_ebreak || w_ecall));
    assign w_xret     = w_sample && !w_trap && bus.privilegedInstrE && is_xret(w_funct12);
    assign w_commit   = w_trap || w_xret;

    always_comb begin
        w_cause = '0;
        if (w_take_irq) begin
            w_cause[XLEN-1] = 1'b1;
            w_cause[7:0]    = CAUSE_IRQ_BASE + {4'b0, w_irq_idx};
        end else if (bus.illegalInstrE) begin
            w_cause[7:0] = CAUSE_ILLEGAL;
        end else if (w_ebreak) begin
            w_cause[7:0] = CAUSE_EBREAK;
        end else begin
            w_cause[7:0] = CAUSE_ECALL;
        end
    end

    // Vectored mode only offsets interrupts; synchronous exceptions go to base.
    assign w_base     = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_target   = (r_mtvec[0] && w_take_irq) ? w_base + XLEN'({w_cause[7:0], 2'b00}) : w_base;
    assign w_mtvec_wr = (VECTORED != 0) ? bus.csrWdata : {bus.csrWdata[XLEN-1:1], 1'b0};

    always_comb begin
        bus.csrRdata = '0;
        case (bus.csrAddr)
            CSR_MSTATUS: begin
                bus.csrRdata[MSTATUS_MIE_BIT]  = r_mstatus_mie;
                bus.csrRdata[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
            end
            CSR_MIE:    bus.csrRdata = XLEN'(r_mie);
            CSR_MTVEC:  bus.csrRdata = r_mtvec;
            CSR_MEPC:   bus.csrRdata = r_mepc;
            CSR_MCAUSE: bus.csrRdata = r_mcause;
            default:    bus.csrRdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_redirect_pc  <= '0;
            r_iret         <= 1'b0;
            r_exception    <= 1'b0;
            r_exc_code     <= '0;
        end else begin
            r_iret      <= w_xret;
            r_exception <= w_trap;

            case (r_state)
                S_RUN:      if (w_commit) r_state <= S_REDIRECT;
                S_REDIRECT: if (bus.redirectAck) r_state <= S_RUN;
                default:    r_state <= S_RUN;
            endcase

            // A commit owns mstatus/mepc/mcause on its edge; a concurrent write there is dropped.
            if (w_trap) begin
                r_mepc         <= {bus.pcE[XLEN-1:2], 2'b00};
                r_mcause       <= w_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_redirect_pc  <= w_target;
                r_exc_code     <= w_cause[7:0];
            end else if (w_xret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
                r_redirect_pc  <= r_mepc;
            end else if (bus.csrWe) begin
                case (bus.csrAddr)
                    CSR_MSTATUS: begin
                        r_mstatus_mie  <= bus.csrWdata[MSTATUS_MIE_BIT];
                        r_mstatus_mpie <= bus.csrWdata[MSTATUS_MPIE_BIT];
                    end
                    CSR_MEPC:   r_mepc   <= {bus.csrWdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: r_mcause <= bus.csrWdata;
                    default: ;
                endcase
            end

            if (bus.csrWe && bus.csrAddr == CSR_MIE)   r_mie   <= bus.csrWdata[NUM_IRQ-1:0];
            if (bus.csrWe && bus.csrAddr == CSR_MTVEC) r_mtvec <= w_mtvec_wr;
        end
    end

    assign bus.redirect      = (r_state == S_REDIRECT);
    assign bus.flush         = (r_state == S_REDIRECT);
    assign bus.redirectPc    = r_redirect_pc;
    assign bus.iret          = r_iret;
    assign bus.exception     = r_exception;
    assign bus.exceptionCode = r_exc_code;

endmodule

// File: tb/tb_trap_unit.sv
// Directed plus randomized bench for trap_unit against a behavioural model
// of the trap/xRET/CSR rules.
module tb_trap_unit;
    import trap_pkg::*;

    localparam int XLEN = 32;
    localparam int NI   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    trap_unit_if #(.XLEN(XLEN), .NUM_IRQ(NI)) bus();

    trap_unit #(
        .XLEN(XLEN), .NUM_IRQ(NI), .VECTORED(1), .RESET_VEC(32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_mstat_mie, m_mstat_mpie;
    logic [3:0]  m_mie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_rpc;
    logic        m_redir, m_iret, m_exc;
    logic [7:0]  m_code;

    logic [11:0] addrs [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h123};
    logic [11:0] f12s  [6] = '{12'h000, 12'h001, 12'h002, 12'h102, 12'h302, 12'h105};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_csr(input logic [11:0] a);
        case (a)
            12'h300: return {24'b0, m_mstat_mpie, 3'b0, m_mstat_mie, 3'b0};
            12'h304: return {28'b0, m_mie};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstat_mie = 0; m_mstat_mpie = 0; m_mie = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_rpc = 0;
        m_redir = 0; m_iret = 0; m_exc = 0; m_code = 0;
    endtask

    task automatic idle();
        bus.validE = 0; bus.privilegedInstrE = 0; bus.illegalInstrE = 0;
        bus.immExtE = 0; bus.pcE = 0; bus.irq = 0;
        bus.csrWe = 0; bus.csrAddr = 0; bus.csrWdata = 0; bus.redirectAck = 0;
    endtask

    // Predict the effect of the current inputs, clock once, compare everything visible.
    task automatic step(input string tag);
        logic        trap, xret;
        logic [31:0] cause, base, tgt;
        int          hit;
        trap = 0; xret = 0; cause = 0; tgt = 0; hit = -1;
        m_iret = 0; m_exc = 0;
        if (!m_redir && bus.validE) begin
            for (int i = NI - 1; i >= 0; i--)
                if (bus.irq[i] && m_mie[i]) hit = i;
            if (m_mstat_mie && hit >= 0) begin
                trap = 1; cause = 32'h8000_0000 + 32'(16 + hit);
            end else if (bus.illegalInstrE) begin
                trap = 1; cause = 2;
            end else if (bus.privilegedInstrE) begin
                case (bus.immExtE[31:20])
                    12'h001: begin trap = 1; cause = 3; end
                    12'h000: begin trap = 1; cause = 11; end
                    12'h002, 12'h102, 12'h302: xret = 1;
                    default: ;
                endcase
            end
        end
        base = m_mtvec & ~32'h3;
        tgt  = (m_mtvec[0] && cause[31]) ? base + 32'(4 * (16 + hit)) : base;

        if (bus.csrWe) begin
            if (bus.csrAddr == 12'h304) m_mie = bus.csrWdata[3:0];
            if (bus.csrAddr == 12'h305) m_mtvec = bus.csrWdata;
            if (!trap && !xret) begin
                if (bus.csrAddr == 12'h300) begin
                    m_mstat_mie = bus.csrWdata[3]; m_mstat_mpie = bus.csrWdata[7];
                end
                if (bus.csrAddr == 12'h341) m_mepc = bus.csrWdata & ~32'h3;
                if (bus.csrAddr == 12'h342) m_mcause = bus.csrWdata;
            end
        end

        if (trap) begin
            m_mepc = bus.pcE & ~32'h3; m_mcause = cause;
            m_mstat_mpie = m_mstat_mie; m_mstat_mie = 0;
            m_rpc = tgt; m_code = cause[7:0]; m_exc = 1; m_redir = 1;
        end else if (xret) begin
            m_mstat_mie = m_mstat_mpie; m_mstat_mpie = 1;
            m_rpc = m_mepc; m_iret = 1; m_redir = 1;
        end else if (m_redir && bus.redirectAck) begin
            m_redir = 0;
        end

        @(posedge clk);
        #1;
        check({tag, "_redirect"},  32'(bus.redirect),      32'(m_redir));
        check({tag, "_flush"},     32'(bus.flush),         32'(m_redir));
        check({tag, "_iret"},      32'(bus.iret),          32'(m_iret));
        check({tag, "_exception"}, 32'(bus.exception),     32'(m_exc));
        check({tag, "_code"},      32'(bus.exceptionCode), 32'(m_code));
        check({tag, "_rpc"},       bus.redirectPc,         m_rpc);
        check({tag, "_csr"},       bus.csrRdata,           model_csr(bus.csrAddr));
        if (tag != "rnd")
            $display("step %s: redirect=%0b exc=%0b code=%0d iret=%0b rpc=%h",
                     tag, bus.redirect, bus.exception, bus.exceptionCode, bus.iret, bus.redirectPc);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d, input string tag);
        bus.csrWe = 1; bus.csrAddr = a; bus.csrWdata = d;
        step(tag);
        bus.csrWe = 0;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_redirect", 32'(bus.redirect),  32'h0);
        check("rst_iret",     32'(bus.iret),      32'h0);
        check("rst_exc",      32'(bus.exception), 32'h0);
        check("rst_rpc",      bus.redirectPc,     32'h0);
        for (int k = 0; k < 6; k++) begin
            bus.csrAddr = addrs[k];
            #1;
            check("rst_csr", bus.csrRdata, 32'h0);
        end
        reset = 0;
        bus.csrAddr = 0;

        // ecall with mtvec=0x100
        csr_write(CSR_MTVEC, 32'h100, "wr_mtvec");
        bus.validE = 1; bus.privilegedInstrE = 1; bus.immExtE = 32'h0; bus.pcE = 32'h40;
        bus.csrAddr = CSR_MEPC;
        step("ecall");
        check("ecall_exc",  32'(bus.exception),     32'h1);
        check("ecall_code", 32'(bus.exceptionCode), 32'd11);
        check("ecall_rpc",  bus.redirectPc,         32'h100);
        check("ecall_mepc", bus.csrRdata,           32'h40);
        idle(); bus.redirectAck = 1;
        step("ecall_ack");
        bus.redirectAck = 0;

        // vectored interrupt, lowest pending index 1
        csr_write(CSR_MSTATUS, 32'h8,   "wr_mstatus");
        csr_write(CSR_MIE,     32'h6,   "wr_mie");
        csr_write(CSR_MTVEC,   32'h201, "wr_mtvec_v");
        bus.validE = 1; bus.irq = 4'b0110; bus.pcE = 32'h50; bus.csrAddr = CSR_MCAUSE;
        step("irq");
        check("irq_cause", bus.csrRdata,   32'h8000_0011);
        check("irq_rpc",   bus.redirectPc, 32'h244);
        bus.csrAddr = CSR_MSTATUS;
        #1;
        check("irq_mstatus", bus.csrRdata, 32'h80);

        // redirect held without ack, irq stays pending
        for (int k = 0; k < 3; k++) begin
            step("hold");
            check("hold_redirect", 32'(bus.redirect), 32'h1);
            check("hold_rpc",      bus.redirectPc,    32'h244);
        end
        bus.redirectAck = 1;
        step("irq_ack");
        check("irq_ack_redirect", 32'(bus.redirect), 32'h0);
        bus.redirectAck = 0;
        step("irq_masked");
        check("masked_exc", 32'(bus.exception), 32'h0);

        // illegal beats ecall
        idle(); bus.validE = 1; bus.illegalInstrE = 1; bus.privilegedInstrE = 1; bus.pcE = 32'h60;
        step("illegal");
        check("illegal_code", 32'(bus.exceptionCode), 32'd2);
        idle(); bus.redirectAck = 1;
        step("illegal_ack");
        idle();

        // mret with a concurrent mepc write that must be lost
        csr_write(CSR_MEPC,    32'h80, "wr_mepc");
        csr_write(CSR_MSTATUS, 32'h80, "wr_mpie");
        bus.validE = 1; bus.privilegedInstrE = 1; bus.immExtE = {12'h302, 20'h0};
        bus.csrWe = 1; bus.csrAddr = CSR_MEPC; bus.csrWdata = 32'h999;
        step("mret");
        check("mret_iret", 32'(bus.iret),  32'h1);
        check("mret_rpc",  bus.redirectPc, 32'h80);
        check("mret_mepc", bus.csrRdata,   32'h80);
        idle(); bus.csrAddr = CSR_MSTATUS;
        #1;
        check("mret_mstatus", bus.csrRdata, 32'h88);
        bus.redirectAck = 1;
        step("mret_ack");
        idle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.validE           = ($urandom_range(0, 3) != 0);
            bus.irq              = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.illegalInstrE    = ($urandom_range(0, 9) == 0);
            bus.privilegedInstrE = ($urandom_range(0, 2) == 0);
            bus.immExtE          = {f12s[$urandom_range(0, 5)], 20'($urandom)};
            bus.pcE              = $urandom;
            bus.csrWe            = ($urandom_range(0, 3) == 0);
            bus.csrAddr          = addrs[$urandom_range(0, 5)];
            bus.csrWdata         = $urandom;
            bus.redirectAck      = 1'($urandom_range(0, 1));
            step("rnd");
        end

        // asynchronous reset while redirecting
        idle(); bus.redirectAck = 1;
        step("pre_rst_ack");
        idle();
        bus.validE = 1; bus.privilegedInstrE = 1; bus.immExtE = 32'h0; bus.pcE = 32'h70;
        step("rst_ecall");
        check("rst_ecall_redirect", 32'(bus.redirect), 32'h1);
        idle();
        reset = 1;
        #1;
        model_reset();
        check("async_redirect", 32'(bus.redirect), 32'h0);
        check("async_flush",    32'(bus.flush),    32'h0);
        for (int k = 0; k < 5; k++) begin
            bus.csrAddr = addrs[k];
            #1;
            check("async_csr", bus.csrRdata, model_csr(addrs[k]));
        end
        reset = 0;
        step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
